// File: rtl/myproject_mul_share_arb_pkg.sv
// Shared constants, operand/product types and helpers for the shared-multiplier arbiter.
package myproject_mul_arb_pkg;

    localparam int A_W = 16;
    localparam int B_W = 13;
    localparam int P_W = 29;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    typedef logic signed [A_W-1:0] operand_a_t;
    typedef logic        [B_W-1:0] operand_b_t;
    typedef logic signed [P_W-1:0] product_t;

endpackage

// File: rtl/myproject_mul_share_arb_if.sv
// Request/response bundle between the MAC lanes and the shared multiplier.
interface myproject_mul_share_arb_if
    import myproject_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
);
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ-1:0]     req_ready;
    logic [N_REQ*A_W-1:0] req_a;
    logic [N_REQ*B_W-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    product_t             rsp_data;
    logic [ID_W-1:0]      rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_id
    );
endinterface

// File: rtl/myproject_mul_share_arb_mul.sv
// Combinational 16-bit signed by 13-bit unsigned multiplier core, exact 29-bit result.
module myproject_mul_16s_13ns_29
    import myproject_mul_arb_pkg::*;
(
    input  operand_a_t a,
    input  operand_b_t b,
    output product_t   p
);
    assign p = product_t'(a) * product_t'(signed'({1'b0, b}));
endmodule

// File: rtl/myproject_mul_share_arb_rr_arbiter.sv
// Round-robin one-hot grant with a last-winner pointer updated only on accept.
module myproject_rr_arbiter
    import myproject_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             en,
    input  logic             accept,
    input  logic [N_REQ-1:0] req_valid,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             grant_any
);
    logic [ID_W-1:0] rr_ptr_reg;
    logic            found;

    // Search starts one past the last winner so the previous winner has lowest priority.
    always_comb begin
        int idx;
        idx       = 0;
        found     = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                found     = 1'b1;
                grant_idx = ID_W'(idx);
            end
        end
    end

    assign grant_any = en && found;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_grant
            assign grant[gi] = grant_any && (grant_idx == ID_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            rr_ptr_reg <= ID_W'(N_REQ - 1);
        end else if (accept) begin
            rr_ptr_reg <= grant_idx;
        end
    end
endmodule

// File: rtl/myproject_mul_share_arb.sv
// One multiplier shared by N_REQ lanes: arbitrated operand stage S1, product stage S2.
module myproject_mul_share_arb
    import myproject_mul_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int ID_W  = clog2(N_REQ)
) (
    input  logic                      ap_clk,
    input  logic                      ap_rst,
    myproject_mul_share_arb_if.slave  bus
);
    logic             s1_en;
    logic             s2_en;
    logic             accept;
    logic             grant_any;
    logic [N_REQ-1:0] grant;
    logic [ID_W-1:0]  grant_idx;

    operand_a_t lane_a [N_REQ];
    operand_b_t lane_b [N_REQ];

    logic            op_valid_reg;
    operand_a_t      op_a_reg;
    operand_b_t      op_b_reg;
    logic [ID_W-1:0] op_id_reg;

    logic            rsp_valid_reg;
    product_t        rsp_data_reg;
    logic [ID_W-1:0] rsp_id_reg;
    product_t        mul_p;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign lane_a[gi] = bus.req_a[gi*A_W +: A_W];
            assign lane_b[gi] = bus.req_b[gi*B_W +: B_W];
        end
    endgenerate

    assign s2_en  = !rsp_valid_reg || bus.rsp_ready;
    assign s1_en  = !op_valid_reg || s2_en;
    assign accept = grant_any && !ap_rst;

    assign bus.req_ready = ap_rst ? '0 : grant;

    myproject_rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_arb (
        .clk       (ap_clk),
        .srst      (ap_rst),
        .en        (s1_en),
        .accept    (accept),
        .req_valid (bus.req_valid),
        .grant     (grant),
        .grant_idx (grant_idx),
        .grant_any (grant_any)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            op_valid_reg <= 1'b0;
            op_a_reg     <= '0;
            op_b_reg     <= '0;
            op_id_reg    <= '0;
        end else if (s1_en) begin
            op_valid_reg <= grant_any;
            if (grant_any) begin
                op_a_reg  <= lane_a[grant_idx];
                op_b_reg  <= lane_b[grant_idx];
                op_id_reg <= grant_idx;
            end
        end
    end

    myproject_mul_16s_13ns_29 u_mul (
        .a (op_a_reg),
        .b (op_b_reg),
        .p (mul_p)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_id_reg    <= '0;
        end else if (s2_en) begin
            rsp_valid_reg <= op_valid_reg;
            rsp_data_reg  <= mul_p;
            rsp_id_reg    <= op_id_reg;
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_id    = rsp_id_reg;
endmodule

// File: tb/tb_myproject_mul_share_arb.sv
// Directed bench for the shared multiplier arbiter with hand-computed products and grant orders.
module tb_myproject_mul_share_arb;
    import myproject_mul_arb_pkg::*;

    localparam int N = 4;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    myproject_mul_share_arb_if #(.N_REQ(N), .ID_W(2)) bus ();

    myproject_mul_share_arb #(.N_REQ(N), .ID_W(2)) dut (
        .ap_clk (ap_clk),
        .ap_rst (ap_rst),
        .bus    (bus)
    );

    always #5 ap_clk = ~ap_clk;

    int total = 0;
    int bad   = 0;
    int ncyc  = 0;

    int lane_a   [N];
    int lane_b   [N];
    int lane_cnt [N];

    int acc_id_q[$];
    int acc_cyc_q[$];
    int rsp_id_q[$];
    int rsp_data_q[$];
    int rsp_cyc_q[$];

    int exp_bp_id   [6] = '{0, 2, 0, 2, 0, 2};
    int exp_bp_data [6] = '{100, 200, 101, 201, 102, 202};
    int exp_fair_id [5] = '{0, 3, 0, 0, 0};

    task automatic check_val(input string tag, input logic signed [31:0] got,
                             input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            bus.req_valid[i]             = (lane_cnt[i] > 0);
            bus.req_a[i*A_W +: A_W]      = A_W'(lane_a[i]);
            bus.req_b[i*B_W +: B_W]      = B_W'(lane_b[i]);
        end
    endtask

    // Sample handshakes mid-cycle, then advance one edge and update requesters that were accepted.
    task automatic tick();
        logic [N-1:0] acc;
        @(negedge ap_clk);
        ncyc++;
        acc = bus.req_valid & bus.req_ready;
        if (!ap_rst) begin
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    acc_id_q.push_back(i);
                    acc_cyc_q.push_back(ncyc);
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                rsp_id_q.push_back(int'(bus.rsp_id));
                rsp_data_q.push_back(int'(bus.rsp_data));
                rsp_cyc_q.push_back(ncyc);
            end
        end
        @(posedge ap_clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (acc[i]) begin
                lane_cnt[i]--;
                lane_a[i]++;
            end
        end
        drive();
    endtask

    task automatic clear_q();
        acc_id_q.delete();
        acc_cyc_q.delete();
        rsp_id_q.delete();
        rsp_data_q.delete();
        rsp_cyc_q.delete();
    endtask

    task automatic run(input string tag, input int n_acc, input int n_rsp, input int limit);
        int k;
        k = 0;
        while ((acc_id_q.size() < n_acc || rsp_id_q.size() < n_rsp) && k < limit) begin
            tick();
            k++;
        end
        check_val({tag, "_done"},
                  ((acc_id_q.size() >= n_acc) && (rsp_id_q.size() >= n_rsp)) ? 1 : 0, 1);
    endtask

    task automatic one_shot(input string tag, input int lane, input int a, input int b,
                            input int exp);
        clear_q();
        lane_a[lane]   = a;
        lane_b[lane]   = b;
        lane_cnt[lane] = 1;
        drive();
        run(tag, 1, 1, 10);
        check_val({tag, "_acc_id"}, acc_id_q[0], lane);
        check_val({tag, "_data"},   rsp_data_q[0], exp);
        check_val({tag, "_id"},     rsp_id_q[0], lane);
        check_val({tag, "_lat"},    rsp_cyc_q[0] - acc_cyc_q[0], 2);
        tick();
        tick();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            lane_a[i]   = i + 1;
            lane_b[i]   = 10;
            lane_cnt[i] = 1;
        end
        bus.rsp_ready = 1'b1;
        ap_rst        = 1'b1;
        drive();

        // Reset: all lanes request, none may be accepted
        tick();
        tick();
        tick();
        check_val("rst_req_ready", bus.req_ready, 0);
        check_val("rst_rsp_valid", bus.rsp_valid, 0);
        check_val("rst_rsp_data",  bus.rsp_data, 0);
        check_val("rst_rsp_id",    bus.rsp_id, 0);
        ap_rst = 1'b0;

        // All four lanes from reset: grants 0..3 back to back
        clear_q();
        run("all4", 4, 4, 20);
        for (int k = 0; k < 4; k++) begin
            check_val($sformatf("all4_acc%0d", k),  acc_id_q[k], k);
            check_val($sformatf("all4_data%0d", k), rsp_data_q[k], 10 * (k + 1));
            check_val($sformatf("all4_id%0d", k),   rsp_id_q[k], k);
        end
        check_val("all4_acc_span", acc_cyc_q[3] - acc_cyc_q[0], 3);
        check_val("all4_rsp_span", rsp_cyc_q[3] - rsp_cyc_q[0], 3);
        check_val("all4_lat",      rsp_cyc_q[0] - acc_cyc_q[0], 2);
        tick();
        tick();

        one_shot("single",   1, 3, 5, 15);
        one_shot("ext_min",  2, -32768, 8191, -268402688);
        one_shot("ext_max",  2, 32767, 8191, 268394497);
        one_shot("ext_zero", 2, -1, 0, 0);

        // Backpressure: lanes 0 and 2 keep requesting while the output is stalled
        clear_q();
        lane_a[0] = 100; lane_b[0] = 1; lane_cnt[0] = 3;
        lane_a[2] = 200; lane_b[2] = 1; lane_cnt[2] = 3;
        bus.rsp_ready = 1'b0;
        drive();
        for (int s = 0; s < 4; s++) begin
            tick();
            if (s >= 2) begin
                check_val($sformatf("bp_ready%0d", s), bus.req_ready, 0);
                check_val($sformatf("bp_valid%0d", s), bus.rsp_valid, 1);
                check_val($sformatf("bp_data%0d", s),  bus.rsp_data, 100);
                check_val($sformatf("bp_id%0d", s),    bus.rsp_id, 0);
            end
        end
        check_val("bp_acc_cnt", acc_id_q.size(), 2);
        bus.rsp_ready = 1'b1;
        run("bp", 6, 6, 30);
        for (int k = 0; k < 6; k++) begin
            check_val($sformatf("bp_acc%0d", k),  acc_id_q[k], exp_bp_id[k]);
            check_val($sformatf("bp_rsp%0d", k),  rsp_data_q[k], exp_bp_data[k]);
            check_val($sformatf("bp_rid%0d", k),  rsp_id_q[k], exp_bp_id[k]);
        end
        tick();
        tick();
        check_val("bp_no_dup", rsp_id_q.size(), 6);

        // Reset with S1 and S2 both occupied
        clear_q();
        lane_a[3] = 11; lane_b[3] = 11; lane_cnt[3] = 1;
        lane_a[1] = 13; lane_b[1] = 13; lane_cnt[1] = 1;
        bus.rsp_ready = 1'b0;
        drive();
        tick();
        tick();
        tick();
        check_val("mrst_full_acc", acc_id_q.size(), 2);
        check_val("mrst_full_vld", bus.rsp_valid, 1);
        lane_a[0] = 7; lane_b[0] = 2; lane_cnt[0] = 1;
        lane_a[1] = 5; lane_b[1] = 3; lane_cnt[1] = 1;
        ap_rst = 1'b1;
        drive();
        tick();
        ap_rst = 1'b0;
        bus.rsp_ready = 1'b1;
        check_val("mrst_rsp_valid", bus.rsp_valid, 0);
        clear_q();
        run("mrst", 2, 2, 15);
        check_val("mrst_acc0", acc_id_q[0], 0);
        check_val("mrst_acc1", acc_id_q[1], 1);
        check_val("mrst_rsp0", rsp_data_q[0], 14);
        check_val("mrst_rsp1", rsp_data_q[1], 15);
        tick();
        tick();
        tick();
        check_val("mrst_no_stale", rsp_id_q.size(), 2);

        // Fairness: lane 3 requests once while lane 0 stays busy
        clear_q();
        lane_a[0] = 1; lane_b[0] = 1; lane_cnt[0] = 4;
        drive();
        tick();
        check_val("fair_first", acc_id_q.size(), 1);
        lane_a[3] = 9; lane_b[3] = 9; lane_cnt[3] = 1;
        drive();
        run("fair", 5, 5, 30);
        for (int k = 0; k < 5; k++) begin
            check_val($sformatf("fair_acc%0d", k), acc_id_q[k], exp_fair_id[k]);
        end
        check_val("fair_rsp3", rsp_data_q[1], 81);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end
endmodule
